// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: captures execute results, runs the data-memory handshake and stalls upstream.
// Optional MEM_TIMEOUT_EN adds a request watchdog that forces completion with a sticky error.
module ex_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              exW,
    input  logic              exFLUSH,
    input  logic [ADDR_W-1:0] exALUout,
    input  logic [ADDR_W-1:0] exrdat2,
    input  logic              excuDRE,
    input  logic              excuDWE,
    input  logic              exMemToReg,
    input  logic              exWEN,
    input  logic [REG_W-1:0]  exwsel,
    input  logic              excuHALT,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic              memstall,
    output logic [ADDR_W-1:0] memALUout,
    output logic [ADDR_W-1:0] memload,
    output logic              memMemToReg,
    output logic              memWEN,
    output logic              memHALT,
    output logic [REG_W-1:0]  memwsel,
    output logic              memerr,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   alu_q, alu_d;
    logic [ADDR_W-1:0]   rdat2_q, rdat2_d;
    logic [ADDR_W-1:0]   load_q, load_d;
    logic                dre_q, dre_d;
    logic                dwe_q, dwe_d;
    logic                m2r_q, m2r_d;
    logic                wen_q, wen_d;
    logic                halt_q, halt_d;
    logic [REG_W-1:0]    wsel_q, wsel_d;
    logic                err_q, err_d;
    logic                timeout_hit;
    logic                in_req;

    // A captured halt makes the whole stage inert until reset.
    assign in_req = (state_q == REQ) && !halt_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = in_req && !dhit && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (in_req && !dhit && !timeout_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        rdat2_d = rdat2_q;
        load_d  = load_q;
        dre_d   = dre_q;
        dwe_d   = dwe_q;
        m2r_d   = m2r_q;
        wen_d   = wen_q;
        halt_d  = halt_q;
        wsel_d  = wsel_q;
        err_d   = err_q;
        if (halt_q) begin
            state_d = state_q;
        end else if (state_q == REQ) begin
            if (dhit) begin
                state_d = DONE;
                if (dre_q) begin
                    load_d = dmemload;
                end
            end else if (timeout_hit) begin
                state_d = DONE;
                err_d   = 1'b1;
                load_d  = ADDR_W'(32'hDEADBEEF);
            end
        end else if (exFLUSH) begin
            state_d = IDLE;
            alu_d   = '0;
            rdat2_d = '0;
            load_d  = '0;
            dre_d   = 1'b0;
            dwe_d   = 1'b0;
            m2r_d   = 1'b0;
            wen_d   = 1'b0;
            halt_d  = 1'b0;
            wsel_d  = '0;
        end else if (exW) begin
            state_d = (excuDRE || excuDWE) ? REQ : IDLE;
            alu_d   = exALUout;
            rdat2_d = exrdat2;
            dre_d   = excuDRE;
            // A read wins over an illegal simultaneous write.
            dwe_d   = excuDWE && !excuDRE;
            m2r_d   = exMemToReg;
            wen_d   = exWEN;
            halt_d  = excuHALT;
            wsel_d  = exwsel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            alu_q   <= '0;
            rdat2_q <= '0;
            load_q  <= '0;
            dre_q   <= 1'b0;
            dwe_q   <= 1'b0;
            m2r_q   <= 1'b0;
            wen_q   <= 1'b0;
            halt_q  <= 1'b0;
            wsel_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            rdat2_q <= rdat2_d;
            load_q  <= load_d;
            dre_q   <= dre_d;
            dwe_q   <= dwe_d;
            m2r_q   <= m2r_d;
            wen_q   <= wen_d;
            halt_q  <= halt_d;
            wsel_q  <= wsel_d;
            err_q   <= err_d;
        end
    end

    assign dmemREN     = in_req && dre_q;
    assign dmemWEN     = in_req && dwe_q;
    assign dmemaddr    = alu_q;
    assign dmemstore   = rdat2_q;
    assign memstall    = in_req;
    assign memALUout   = alu_q;
    assign memload     = load_q;
    assign memMemToReg = m2r_q;
    assign memWEN      = wen_q;
    assign memHALT     = halt_q;
    assign memwsel     = wsel_q;
    assign memerr      = err_q;
    assign state_dbg   = state_q;

endmodule
